// File: rtl/packer_pkg.sv
// Shared constants and helpers for the k-to-n-bit packer.
package packer_pkg;

  localparam int DEF_FACTOR   = 3;
  localparam int DEF_IN_WIDTH = 8;

  // Counter needs at least one bit even when FACTOR is 1.
  function automatic int cnt_width(input int factor);
    return (factor <= 1) ? 1 : $clog2(factor);
  endfunction

  typedef logic [cnt_width(DEF_FACTOR)-1:0] cnt_t;

endpackage

// File: rtl/packer_k_to_nbit_if.sv
// Word-in / packed-word-out bus between the packer and its neighbours.
interface packer_k_to_nbit_if
  import packer_pkg::*;
#(
  parameter int FACTOR   = DEF_FACTOR,
  parameter int IN_WIDTH = DEF_IN_WIDTH
);
  logic [IN_WIDTH-1:0]        data_in;
  logic [FACTOR*IN_WIDTH-1:0] data_out;

  modport master (output data_in, input data_out);
  modport slave  (input data_in, output data_out);
endinterface

// File: rtl/packer_word_counter.sv
// Modulo-FACTOR word counter; last flags the final word of a group.
module packer_word_counter
  import packer_pkg::*;
#(
  parameter int FACTOR = DEF_FACTOR,
  localparam int CW    = cnt_width(FACTOR)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(FACTOR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/packer_k_to_nbit.sv
// Packs FACTOR consecutive IN_WIDTH-bit words into one registered output word.
// Build option: define PACKER_LSB_FIRST_EN to place the first-received word in the LSBs.
module packer_k_to_nbit
  import packer_pkg::*;
#(
  parameter int FACTOR   = DEF_FACTOR,
  parameter int IN_WIDTH = DEF_IN_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  packer_k_to_nbit_if.slave  bus
);

  localparam int CW = cnt_width(FACTOR);
  localparam int SW = (FACTOR > 1) ? FACTOR - 1 : 1;
  localparam int OW = FACTOR * IN_WIDTH;

  if (FACTOR < 1 || IN_WIDTH < 1) begin : g_bad_params
    $error("packer_k_to_nbit: FACTOR and IN_WIDTH must both be >= 1");
  end

  logic [CW-1:0]       cnt;
  logic                last;
  logic [IN_WIDTH-1:0] stage_p0 [SW];
  logic [OW-1:0]       pack_word;
  logic [OW-1:0]       data_out_p1;

  function automatic int slot_base(input int k);
`ifdef PACKER_LSB_FIRST_EN
    return k * IN_WIDTH;
`else
    return (FACTOR - 1 - k) * IN_WIDTH;
`endif
  endfunction

  packer_word_counter #(.FACTOR(FACTOR)) u_counter (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .last (last)
  );

  // Stage p0: hold words 0..FACTOR-2 until the group completes
  always_ff @(posedge clk) begin
    for (int k = 0; k < SW; k++) begin
      if (rst) begin
        stage_p0[k] <= '0;
      end else if (!last && cnt == CW'(k)) begin
        stage_p0[k] <= bus.data_in;
      end
    end
  end

  // The final word bypasses staging so the packed word lands on the same edge.
  always_comb begin
    pack_word = '0;
    for (int k = 0; k < FACTOR - 1; k++) begin
      pack_word[slot_base(k) +: IN_WIDTH] = stage_p0[k];
    end
    pack_word[slot_base(FACTOR - 1) +: IN_WIDTH] = bus.data_in;
  end

  // Stage p1: output register, updated only on group completion
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_p1 <= '0;
    end else if (last) begin
      data_out_p1 <= pack_word;
    end
  end

  assign bus.data_out = data_out_p1;

endmodule

// File: tb/tb_packer_k_to_nbit.sv
// Directed bench for packer_k_to_nbit across several FACTOR/IN_WIDTH variants.
module tb_packer_k_to_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  packer_k_to_nbit_if #(.FACTOR(3), .IN_WIDTH(8))  bus_a ();
  packer_k_to_nbit_if #(.FACTOR(2), .IN_WIDTH(16)) bus_b ();
  packer_k_to_nbit_if #(.FACTOR(3), .IN_WIDTH(10)) bus_c ();
  packer_k_to_nbit_if #(.FACTOR(1), .IN_WIDTH(8))  bus_d ();

  packer_k_to_nbit #(.FACTOR(3), .IN_WIDTH(8))  dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  packer_k_to_nbit #(.FACTOR(2), .IN_WIDTH(16)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  packer_k_to_nbit #(.FACTOR(3), .IN_WIDTH(10)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  packer_k_to_nbit #(.FACTOR(1), .IN_WIDTH(8))  dut_d (.clk(clk), .rst(rst), .bus(bus_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.data_in = 8'hFF;
    bus_b.data_in = 16'hFFFF;
    bus_c.data_in = 10'h3FF;
    bus_d.data_in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus_a.data_out !== 24'h000000) begin
        bad++;
        $display("FAIL reset_a[%0d] got=%h want=000000", i, bus_a.data_out);
      end
      total++;
      if (bus_b.data_out !== 32'h00000000) begin
        bad++;
        $display("FAIL reset_b[%0d] got=%h want=00000000", i, bus_b.data_out);
      end
      total++;
      if (bus_c.data_out !== 30'h0) begin
        bad++;
        $display("FAIL reset_c[%0d] got=%h want=0", i, bus_c.data_out);
      end
      total++;
      if (bus_d.data_out !== 8'h00) begin
        bad++;
        $display("FAIL reset_d[%0d] got=%h want=00", i, bus_d.data_out);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0]  words [6];
    logic [23:0] exp   [6];
    words = '{8'h1A, 8'h2A, 8'h3A, 8'h4A, 8'h5A, 8'h6A};
`ifdef PACKER_LSB_FIRST_EN
    exp = '{24'h0, 24'h0, 24'h3A2A1A, 24'h3A2A1A, 24'h3A2A1A, 24'h6A5A4A};
`else
    exp = '{24'h0, 24'h0, 24'h1A2A3A, 24'h1A2A3A, 24'h1A2A3A, 24'h4A5A6A};
`endif
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_a.data_in = words[i];
      tick();
      total++;
      if (bus_a.data_out !== exp[i]) begin
        bad++;
        $display("FAIL basic[%0d] got=%h want=%h", i, bus_a.data_out, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  words [6];
    logic        rsts  [6];
    logic [23:0] exp   [6];
    words = '{8'h1A, 8'h2A, 8'h3A, 8'h7A, 8'h8A, 8'h9A};
    rsts  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef PACKER_LSB_FIRST_EN
    exp = '{24'h6A5A4A, 24'h6A5A4A, 24'h0, 24'h0, 24'h0, 24'h9A8A7A};
`else
    exp = '{24'h4A5A6A, 24'h4A5A6A, 24'h0, 24'h0, 24'h0, 24'h7A8A9A};
`endif
    for (int i = 0; i < 6; i++) begin
      rst = rsts[i];
      bus_a.data_in = words[i];
      tick();
      total++;
      if (bus_a.data_out !== exp[i]) begin
        bad++;
        $display("FAIL reset_mid[%0d] got=%h want=%h", i, bus_a.data_out, exp[i]);
      end
    end
  endtask

  task automatic test_width16();
    logic [31:0] exp_full;
`ifdef PACKER_LSB_FIRST_EN
    exp_full = 32'h3A4A1A2A;
`else
    exp_full = 32'h1A2A3A4A;
`endif
    do_reset();
    rst = 1'b0;
    bus_b.data_in = 16'h1A2A;
    tick();
    total++;
    if (bus_b.data_out !== 32'h0) begin
      bad++;
      $display("FAIL w16_partial got=%h want=00000000", bus_b.data_out);
    end
    bus_b.data_in = 16'h3A4A;
    tick();
    total++;
    if (bus_b.data_out !== exp_full) begin
      bad++;
      $display("FAIL w16_full got=%h want=%h", bus_b.data_out, exp_full);
    end
  endtask

  task automatic test_width10();
    logic [9:0]  words [3];
    logic [29:0] exp   [3];
    words = '{10'h21A, 10'h22A, 10'h23A};
`ifdef PACKER_LSB_FIRST_EN
    exp = '{30'h0, 30'h0, {10'h23A, 10'h22A, 10'h21A}};
`else
    exp = '{30'h0, 30'h0, {10'h21A, 10'h22A, 10'h23A}};
`endif
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_c.data_in = words[i];
      tick();
      total++;
      if (bus_c.data_out !== exp[i]) begin
        bad++;
        $display("FAIL w10[%0d] got=%h want=%h", i, bus_c.data_out, exp[i]);
      end
    end
  endtask

  task automatic test_factor1();
    logic [7:0] words [3];
    words = '{8'h1A, 8'h2A, 8'h5B};
    do_reset();
    total++;
    if (bus_d.data_out !== 8'h00) begin
      bad++;
      $display("FAIL f1_reset got=%h want=00", bus_d.data_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_d.data_in = words[i];
      tick();
      total++;
      if (bus_d.data_out !== words[i]) begin
        bad++;
        $display("FAIL f1[%0d] got=%h want=%h", i, bus_d.data_out, words[i]);
      end
    end
  endtask

  initial begin
    bus_a.data_in = '0;
    bus_b.data_in = '0;
    bus_c.data_in = '0;
    bus_d.data_in = '0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_width16();
    test_width10();
    test_factor1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
